vga_timing_gen: RTL and testbench

- Pixel-timing stage directly upstream of every sprite/ROM rendering stage.
- Generates DrawX/DrawY raster coordinates, active-video `blank`, and active-low hs/vs for 640x480@60 Hz on the 25 MHz vga_clk.
- Also supplies hs/vs/blank delayed by the downstream render pipeline depth, plus line/frame strobes. Downstream stages use the strobes to latch per-frame state.

---
 rtl/vga_timing_pkg.sv | 57 +++++
 rtl/vga_sync_delay.sv | 45 ++++
 rtl/vga_timing_gen.sv | 150 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared constants, types and helpers for the VGA raster
// timing slice.
//   COORD_W         : width of the DrawX/DrawY raster coordinates
//   DEF_*           : default 640x480@60 Hz timing (25 MHz pixel clock)
//   coord_t         : raster coordinate type
//   coord_cmp_t     : coordinate widened by one bit, so that boundaries equal
//                     to 2**COORD_W can be compared without truncation
//   sync_t          : {blank, hs, vs} bundle carried by the delay line
//   h_total/v_total : sum of the four timing segments of one axis
package vga_timing_pkg;

    localparam int unsigned COORD_W     = 10;
    localparam int unsigned COORD_LIMIT = 1 << COORD_W;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    localparam int unsigned DEF_SYNC_DLY  = 2;
    localparam int unsigned MAX_SYNC_DLY  = 7;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COORD_W:0]   coord_cmp_t;

    typedef struct packed {
        logic blank;
        logic hs;
        logic vs;
    } sync_t;

    // Idle state of the sync bundle: blanking, both syncs de-asserted (high).
    localparam sync_t SYNC_RESET = '{blank: 1'b0, hs: 1'b1, vs: 1'b1};

    function automatic int unsigned h_total(
        input int unsigned visible = DEF_H_VISIBLE,
        input int unsigned front   = DEF_H_FRONT,
        input int unsigned sync    = DEF_H_SYNC,
        input int unsigned back    = DEF_H_BACK
    );
        return visible + front + sync + back;
    endfunction

    function automatic int unsigned v_total(
        input int unsigned visible = DEF_V_VISIBLE,
        input int unsigned front   = DEF_V_FRONT,
        input int unsigned sync    = DEF_V_SYNC,
        input int unsigned back    = DEF_V_BACK
    );
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: DEPTH-stage shift register that aligns the sync bundle with
// a downstream render pipeline. Every stage advances on every clock.
//   i_clk   : pixel clock
//   i_rst_n : asynchronous active-low reset, loads RST_VAL into every stage
//   i_data  : undelayed bundle
//   o_data  : i_data delayed by DEPTH clocks (DEPTH = 0 is a straight wire)
module vga_sync_delay
    import vga_timing_pkg::*;
#(
    parameter int unsigned       DEPTH   = DEF_SYNC_DLY,
    parameter int unsigned       WIDTH   = $bits(sync_t),
    parameter logic [WIDTH-1:0]  RST_VAL = SYNC_RESET
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_clk;
            assign w_unused_clk = i_clk ^ i_rst_n;
            assign o_data = i_data;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int unsigned k = 0; k < DEPTH; k++) begin
                        r_stage[k] <= RST_VAL;
                    end
                end else begin
                    r_stage[0] <= i_data;
                    for (int unsigned k = 1; k < DEPTH; k++) begin
                        r_stage[k] <= r_stage[k-1];
                    end
                end
            end

            assign o_data = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing generator (640x480@60 Hz by
// default). All outputs are registered.
//   vga_clk     : pixel clock
//   reset_n     : asynchronous active-low reset; restarts the raster so the
//                 first edge after release shows (0,0)
//   DrawX/DrawY : current pixel column / row
//   blank       : 1 = active video, 0 = blanking
//   hs/vs       : horizontal / vertical sync, active low
//   *_dly       : blank/hs/vs delayed by SYNC_DLY clocks (0..7)
//   line_start  : one-clock pulse on DrawX == 0
//   frame_start : one-clock pulse on DrawX == 0 and DrawY == 0
//   frame_count : frame counter, built only when VGA_FRAME_COUNTER_EN is
//                 defined; otherwise tied to zero
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter int unsigned SYNC_DLY  = DEF_SYNC_DLY
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    output logic [COORD_W-1:0] DrawX,
    output logic [COORD_W-1:0] DrawY,
    output logic               blank,
    output logic               hs,
    output logic               vs,
    output logic               blank_dly,
    output logic               hs_dly,
    output logic               vs_dly,
    output logic               line_start,
    output logic               frame_start,
    output logic [7:0]         frame_count
);

    localparam int unsigned H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

    localparam coord_cmp_t H_VIS      = coord_cmp_t'(H_VISIBLE);
    localparam coord_cmp_t H_SYNC_BEG = coord_cmp_t'(H_VISIBLE + H_FRONT);
    localparam coord_cmp_t H_SYNC_END = coord_cmp_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_cmp_t V_VIS      = coord_cmp_t'(V_VISIBLE);
    localparam coord_cmp_t V_SYNC_BEG = coord_cmp_t'(V_VISIBLE + V_FRONT);
    localparam coord_cmp_t V_SYNC_END = coord_cmp_t'(V_VISIBLE + V_FRONT + V_SYNC);

    generate
        if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the coordinate range");
        end
        if (SYNC_DLY > MAX_SYNC_DLY) begin : g_bad_dly
            $error("vga_timing_gen: SYNC_DLY out of range 0..7");
        end
    endgenerate

    coord_t     r_hc;
    coord_t     r_vc;
    coord_t     w_hc_next;
    coord_t     w_vc_next;
    logic       w_h_wrap;
    coord_cmp_t w_hc_cmp;
    coord_cmp_t w_vc_cmp;

    logic       r_blank;
    logic       r_hs;
    logic       r_vs;
    logic       r_line_start;
    logic       r_frame_start;
    sync_t      w_sync_dly;

    always_comb begin
        w_h_wrap  = (r_hc == H_LAST);
        w_hc_next = w_h_wrap ? '0 : r_hc + coord_t'(1);
        w_vc_next = r_vc;
        if (w_h_wrap) begin
            w_vc_next = (r_vc == V_LAST) ? '0 : r_vc + coord_t'(1);
        end
        w_hc_cmp = {1'b0, w_hc_next};
        w_vc_cmp = {1'b0, w_vc_next};
    end

    // Flags are decoded from the next counter values so that, once
    // registered, they line up with the DrawX/DrawY they describe.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hc          <= H_LAST;
            r_vc          <= V_LAST;
            r_blank       <= SYNC_RESET.blank;
            r_hs          <= SYNC_RESET.hs;
            r_vs          <= SYNC_RESET.vs;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hc          <= w_hc_next;
            r_vc          <= w_vc_next;
            r_blank       <= (w_hc_cmp < H_VIS) && (w_vc_cmp < V_VIS);
            r_hs          <= !((w_hc_cmp >= H_SYNC_BEG) && (w_hc_cmp < H_SYNC_END));
            r_vs          <= !((w_vc_cmp >= V_SYNC_BEG) && (w_vc_cmp < V_SYNC_END));
            r_line_start  <= (w_hc_next == '0);
            r_frame_start <= (w_hc_next == '0) && (w_vc_next == '0);
        end
    end

    vga_sync_delay #(
        .DEPTH   (SYNC_DLY),
        .WIDTH   ($bits(sync_t)),
        .RST_VAL (SYNC_RESET)
    ) u_sync_delay (
        .i_clk   (vga_clk),
        .i_rst_n (reset_n),
        .i_data  ({r_blank, r_hs, r_vs}),
        .o_data  (w_sync_dly)
    );

`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] r_frame_count;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_count <= '0;
        end else if (r_frame_start) begin
            r_frame_count <= r_frame_count + 8'd1;
        end
    end

    assign frame_count = r_frame_count;
`else
    assign frame_count = '0;
`endif

    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign blank       = r_blank;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign blank_dly   = w_sync_dly.blank;
    assign hs_dly      = w_sync_dly.hs;
    assign vs_dly      = w_sync_dly.vs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks three vga_timing_gen instances (full 640x480 with
// SYNC_DLY=2, a small raster with SYNC_DLY=0, a tiny raster with SYNC_DLY=3)
// against a model that derives every output from the clock count since reset
// release. Honours VGA_FRAME_COUNTER_EN for the frame_count expectation.
module tb_vga_timing_gen;

    typedef struct packed {
        int hv, hf, hs, hb, vv, vf, vs, vb, d;
    } geom_t;

    typedef struct packed {
        logic [9:0] x, y;
        logic       blank, hs, vs, ls, fs;
    } raster_t;

    typedef struct packed {
        logic [9:0] x, y;
        logic       blank, hs, vs, bd, hd, vd, ls, fs;
        logic [7:0] fc;
    } obs_t;

    localparam geom_t G0 = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
    localparam geom_t G1 = '{16, 2, 4, 3, 12, 2, 2, 3, 0};
    localparam geom_t G2 = '{4, 1, 1, 2, 2, 1, 1, 1, 3};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    longint cyc = -1;
    int checks   = 0;
    int failures = 0;

    logic [9:0] dx [3];
    logic [9:0] dy [3];
    logic [7:0] fc [3];
    logic bl [3], hs [3], vs [3], bd [3], hd [3], vd [3], ls [3], fs [3];

    always #5 clk = ~clk;

    // Clock edges elapsed since reset release; -1 while in reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= -1;
        else        cyc <= cyc + 1;
    end

    vga_timing_gen #(
        .H_VISIBLE(G0.hv), .H_FRONT(G0.hf), .H_SYNC(G0.hs), .H_BACK(G0.hb),
        .V_VISIBLE(G0.vv), .V_FRONT(G0.vf), .V_SYNC(G0.vs), .V_BACK(G0.vb),
        .SYNC_DLY(G0.d)
    ) u_dut0 (
        .vga_clk(clk), .reset_n(rst_n), .DrawX(dx[0]), .DrawY(dy[0]),
        .blank(bl[0]), .hs(hs[0]), .vs(vs[0]), .blank_dly(bd[0]),
        .hs_dly(hd[0]), .vs_dly(vd[0]), .line_start(ls[0]),
        .frame_start(fs[0]), .frame_count(fc[0])
    );

    vga_timing_gen #(
        .H_VISIBLE(G1.hv), .H_FRONT(G1.hf), .H_SYNC(G1.hs), .H_BACK(G1.hb),
        .V_VISIBLE(G1.vv), .V_FRONT(G1.vf), .V_SYNC(G1.vs), .V_BACK(G1.vb),
        .SYNC_DLY(G1.d)
    ) u_dut1 (
        .vga_clk(clk), .reset_n(rst_n), .DrawX(dx[1]), .DrawY(dy[1]),
        .blank(bl[1]), .hs(hs[1]), .vs(vs[1]), .blank_dly(bd[1]),
        .hs_dly(hd[1]), .vs_dly(vd[1]), .line_start(ls[1]),
        .frame_start(fs[1]), .frame_count(fc[1])
    );

    vga_timing_gen #(
        .H_VISIBLE(G2.hv), .H_FRONT(G2.hf), .H_SYNC(G2.hs), .H_BACK(G2.hb),
        .V_VISIBLE(G2.vv), .V_FRONT(G2.vf), .V_SYNC(G2.vs), .V_BACK(G2.vb),
        .SYNC_DLY(G2.d)
    ) u_dut2 (
        .vga_clk(clk), .reset_n(rst_n), .DrawX(dx[2]), .DrawY(dy[2]),
        .blank(bl[2]), .hs(hs[2]), .vs(vs[2]), .blank_dly(bd[2]),
        .hs_dly(hd[2]), .vs_dly(vd[2]), .line_start(ls[2]),
        .frame_start(fs[2]), .frame_count(fc[2])
    );

    function automatic geom_t geom(int i);
        case (i)
            0:       return G0;
            1:       return G1;
            default: return G2;
        endcase
    endfunction

    function automatic obs_t sample(int i);
        obs_t o;
        o.x = dx[i]; o.y = dy[i];
        o.blank = bl[i]; o.hs = hs[i]; o.vs = vs[i];
        o.bd = bd[i]; o.hd = hd[i]; o.vd = vd[i];
        o.ls = ls[i]; o.fs = fs[i]; o.fc = fc[i];
        return o;
    endfunction

    // Raster state u clocks after release; u < 0 is the reset state.
    function automatic raster_t raster_at(geom_t g, longint u);
        raster_t r;
        longint ht, vt, hc, vc;
        ht = longint'(g.hv + g.hf + g.hs + g.hb);
        vt = longint'(g.vv + g.vf + g.vs + g.vb);
        if (u < 0) begin
            r = '{x: 10'(ht - 1), y: 10'(vt - 1), blank: 1'b0, hs: 1'b1,
                  vs: 1'b1, ls: 1'b0, fs: 1'b0};
            return r;
        end
        hc = u % ht;
        vc = (u / ht) % vt;
        r.x     = 10'(hc);
        r.y     = 10'(vc);
        r.blank = (hc < g.hv) && (vc < g.vv);
        r.hs    = !((hc >= g.hv + g.hf) && (hc < g.hv + g.hf + g.hs));
        r.vs    = !((vc >= g.vv + g.vf) && (vc < g.vv + g.vf + g.vs));
        r.ls    = (hc == 0);
        r.fs    = (u % (ht * vt)) == 0;
        return r;
    endfunction

    function automatic obs_t model(geom_t g, longint t);
        obs_t e;
        raster_t now, old;
        longint ft;
        now = raster_at(g, t);
        old = raster_at(g, t - g.d);
        ft  = longint'(g.hv + g.hf + g.hs + g.hb) * longint'(g.vv + g.vf + g.vs + g.vb);
        e.x = now.x; e.y = now.y;
        e.blank = now.blank; e.hs = now.hs; e.vs = now.vs;
        e.bd = old.blank; e.hd = old.hs; e.vd = old.vs;
        e.ls = now.ls; e.fs = now.fs;
`ifdef VGA_FRAME_COUNTER_EN
        e.fc = (t <= 0) ? 8'd0 : 8'(((t - 1) / ft) + 1);
`else
        e.fc = (ft > 0) ? 8'd0 : 8'd0;
`endif
        return e;
    endfunction

    task automatic test_reset();
        obs_t o, e;
        rst_n = 1'b0;
        repeat (5) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                o = sample(i); e = model(geom(i), cyc);
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL reset_hold inst%0d: got %h expected %h", i, o, e);
                end
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            o = sample(i); e = model(geom(i), cyc);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_release inst%0d t=%0d: got %h expected %h", i, cyc, o, e);
            end
        end
        o = sample(0);
        checks++;
        if (o.x !== 10'd0 || o.y !== 10'd0 || o.blank !== 1'b1 || o.fs !== 1'b1 || o.ls !== 1'b1) begin
            failures++;
            $display("FAIL first_pixel: got x=%0d y=%0d blank=%b fs=%b ls=%b required 0 0 1 1 1",
                     o.x, o.y, o.blank, o.fs, o.ls);
        end
    endtask

    task automatic test_line_timing();
        obs_t o, e;
        longint ls_prev = -1;
        int hs_low = 0;
        logic prev_blank = 1'b1;
        int n = 2 * 800 + int'($urandom_range(10, 60));
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                o = sample(i); e = model(geom(i), cyc);
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL line_raster inst%0d t=%0d: got %h expected %h", i, cyc, o, e);
                end
            end
            o = sample(0);
            if (o.ls) begin
                if (ls_prev >= 0) begin
                    checks++;
                    if (cyc - ls_prev != 800) begin
                        failures++;
                        $display("FAIL line_period: got %0d required 800", cyc - ls_prev);
                    end
                end
                ls_prev = cyc;
            end
            if (o.y == 10'd0 && !o.hs) hs_low++;
            if (prev_blank && !o.blank) begin
                checks++;
                if (o.x !== 10'(G0.hv)) begin
                    failures++;
                    $display("FAIL blank_fall: got DrawX=%0d required %0d", o.x, G0.hv);
                end
            end
            prev_blank = o.blank;
        end
        checks++;
        if (hs_low != G0.hs) begin
            failures++;
            $display("FAIL hs_width: got %0d required %0d", hs_low, G0.hs);
        end
    endtask

    task automatic test_delay_alignment();
        obs_t o, e, p;
        longint hs_fall = -1, hd_fall = -1, bl_rise = -1, bd_rise = -1;
        p = sample(0);
        repeat (900) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                o = sample(i); e = model(geom(i), cyc);
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL dly_raster inst%0d t=%0d: got %h expected %h", i, cyc, o, e);
                end
            end
            o = sample(1);
            checks++;
            if ({o.bd, o.hd, o.vd} !== {o.blank, o.hs, o.vs}) begin
                failures++;
                $display("FAIL dly0_passthru t=%0d: got %b required %b", cyc,
                         {o.bd, o.hd, o.vd}, {o.blank, o.hs, o.vs});
            end
            o = sample(0);
            if (p.hs && !o.hs && hs_fall < 0) hs_fall = cyc;
            if (p.hd && !o.hd && hs_fall >= 0 && hd_fall < 0) hd_fall = cyc;
            if (!p.blank && o.blank && bl_rise < 0) bl_rise = cyc;
            if (!p.bd && o.bd && bl_rise >= 0 && bd_rise < 0) bd_rise = cyc;
            p = o;
        end
        checks++;
        if (hs_fall < 0 || hd_fall - hs_fall != G0.d) begin
            failures++;
            $display("FAIL hs_dly_align: got %0d required %0d", hd_fall - hs_fall, G0.d);
        end
        checks++;
        if (bl_rise < 0 || bd_rise - bl_rise != G0.d) begin
            failures++;
            $display("FAIL blank_dly_align: got %0d required %0d", bd_rise - bl_rise, G0.d);
        end
    endtask

    task automatic test_frame_timing();
        obs_t o, e;
        longint fs_prev = -1;
        int vs_low = 0;
        int ht = G1.hv + G1.hf + G1.hs + G1.hb;
        int ft = ht * (G1.vv + G1.vf + G1.vs + G1.vb);
        repeat (3 * ft + 5) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                o = sample(i); e = model(geom(i), cyc);
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL frame_raster inst%0d t=%0d: got %h expected %h", i, cyc, o, e);
                end
            end
            o = sample(1);
            if (o.fs) begin
                if (fs_prev >= 0) begin
                    checks++;
                    if (cyc - fs_prev != ft) begin
                        failures++;
                        $display("FAIL frame_period: got %0d required %0d", cyc - fs_prev, ft);
                    end
                    checks++;
                    if (vs_low != G1.vs * ht) begin
                        failures++;
                        $display("FAIL vs_width: got %0d required %0d", vs_low, G1.vs * ht);
                    end
                end
                fs_prev = cyc;
                vs_low = 0;
            end
            if (!o.vs) vs_low++;
            if (o.y >= 10'(G1.vv)) begin
                checks++;
                if (o.blank !== 1'b0) begin
                    failures++;
                    $display("FAIL vblank: got blank=%b at DrawY=%0d required 0", o.blank, o.y);
                end
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        obs_t o, e;
        repeat (3) begin
            repeat (int'($urandom_range(50, 450))) begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    o = sample(i); e = model(geom(i), cyc);
                    checks++;
                    if (o !== e) begin
                        failures++;
                        $display("FAIL pre_reset inst%0d t=%0d: got %h expected %h", i, cyc, o, e);
                    end
                end
            end
            #1 rst_n = 1'b0;
            #1;
            for (int i = 0; i < 3; i++) begin
                o = sample(i); e = model(geom(i), -1);
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL async_reset inst%0d: got %h expected %h", i, o, e);
                end
            end
            repeat (int'($urandom_range(1, 4))) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                o = sample(i); e = model(geom(i), cyc);
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL restart inst%0d t=%0d: got %h expected %h", i, cyc, o, e);
                end
            end
        end
    endtask

    task automatic test_frame_counter();
        obs_t o, e;
        int pulses = 0;
        int pending = 0;
        logic [7:0] want;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (256 * 40 + int'($urandom_range(5, 40))) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                o = sample(i); e = model(geom(i), cyc);
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL fc_raster inst%0d t=%0d: got %h expected %h", i, cyc, o, e);
                end
            end
            o = sample(2);
            if (pending != 0) begin
`ifdef VGA_FRAME_COUNTER_EN
                want = 8'(pending);
`else
                want = 8'd0;
`endif
                checks++;
                if (o.fc !== want) begin
                    failures++;
                    $display("FAIL frame_count after %0d pulses: got %0d required %0d",
                             pending, o.fc, want);
                end
                pending = 0;
            end
            if (o.fs) begin
                pulses++;
                if (pulses == 3 || pulses == 256) pending = pulses;
            end
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_delay_alignment();
        test_frame_timing();
        test_mid_frame_reset();
        test_frame_counter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
